// File: rtl/decode_writeback.sv
// Decode + write-back stage of the sequential Y86-64 core.
// Owns the program register file (NREG x WIDTH). It decodes srcA/srcB/dstE/dstM
// from iCode/rA/rB/cnd and reads valA/valB/dbg_data asynchronously from the
// array. On each rising clock edge it commits valE/valM.
// Ports:
//   clk, rst         clock; synchronous active-high reset that clears the file
//   iCode, rA, rB    instruction code and register specifiers from fetch
//   cnd              condition flag from execute, gates cmovXX
//   wb_en            write-back enable; 0 suppresses all register writes
//   valE, valM       ALU result and memory data to commit
//   srcA..dstM       decoded register IDs (4'hF = none)
//   valA, valB       register read data for execute (0 for ID 4'hF)
//   dbg_sel/dbg_data debug read port (0 for ID 4'hF)
module decode_writeback #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NREG   = 15,
    parameter logic [3:0]  RSP_ID = 4'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       iCode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic             wb_en,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [WIDTH-1:0] r_regs [NREG];

    logic w_we_e;
    logic w_we_m;

    // Register ID decode; anything not listed (halt, nop, jXX, illegal) uses no registers.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (iCode)
            I_CMOV: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOV: begin
                dstE = rB;
            end
            I_RMMOV: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOV: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_RET: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_POPQ: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
                dstM = rA;
            end
            default: begin
                srcA = RNONE;
            end
        endcase
    end

    // Asynchronous read ports; IDs outside the array (RNONE) read as zero.
    always_comb begin
        valA = '0;
        if (32'(srcA) < NREG) valA = r_regs[srcA];
    end

    always_comb begin
        valB = '0;
        if (32'(srcB) < NREG) valB = r_regs[srcB];
    end

    always_comb begin
        dbg_data = '0;
        if (32'(dbg_sel) < NREG) dbg_data = r_regs[dbg_sel];
    end

    // When both ports target the same register (popq %rsp), the M write takes precedence.
    assign w_we_e = wb_en && (32'(dstE) < NREG) && (dstE != dstM);
    assign w_we_m = wb_en && (32'(dstM) < NREG);

    // Register file update; reset clears every entry and beats any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we_e) r_regs[dstE] <= valE;
            if (w_we_m) r_regs[dstM] <= valM;
        end
    end

endmodule
